// File: rtl/train_pkt_gen_pkg.sv
// Shared constants for the packet-train generator.
// FSM encodings, frame byte offsets and length limits.
package train_pkt_gen_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam int DATA_W    = 64;
    localparam int HDR_BYTES = 18;
    localparam int MARK_LO   = 42;
    localparam int MARK_HI   = 49;
    localparam int PKT_MIN   = 60;
    localparam int PKT_MAX   = 1514;

endpackage

// File: rtl/train_pkt_gen_if.sv
// AXI4-Stream bundle between the generator and the TX queue.
// master drives the beat, slave drives tready.
interface train_pkt_gen_if;
    import train_pkt_gen_pkg::*;

    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (
        output tdata, tstrb, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tvalid, tlast,
        output tready
    );

endinterface

// File: rtl/train_pkt_gen_word_fmt.sv
// Combinational beat formatter: beat index + latched config -> beat.
// Bytes past the end of the frame are driven as zero.
module train_pkt_gen_word_fmt
    import train_pkt_gen_pkg::*;
#(
    parameter int          CNT_WIDTH = 16,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic [CNT_WIDTH-1:0] beat,
    input  logic [CNT_WIDTH-1:0] nbeats,
    input  logic [2:0]           rem,
    input  logic [CNT_WIDTH-1:0] train_len,
    input  logic [CNT_WIDTH-1:0] seq,
    input  logic [47:0]          dst_mac,
    input  logic [47:0]          src_mac,
    output logic [DATA_W-1:0]    data,
    output logic [DATA_W/8-1:0]  strb,
    output logic                 last
);

    localparam int IW = CNT_WIDTH + 3;

    logic [8*HDR_BYTES-1:0] hdr;
    logic [3:0]             sh;
    logic [IW-1:0]          idx;

    assign hdr = {dst_mac, src_mac, ETHERTYPE,
                  seq[15:0], train_len[15:0]};

    function automatic logic [7:0] byte_at(input logic [IW-1:0] i);
        logic [7:0] v;
        v = 8'h00;
        if (i < IW'(HDR_BYTES)) begin
            for (int k = 0; k < HDR_BYTES; k++)
                if (i == IW'(k))
                    v = hdr[8*(HDR_BYTES-1-k) +: 8];
        end else if (i < IW'(MARK_LO)) begin
            v = 8'h00;
        end else if (i <= IW'(MARK_HI)) begin
            v = 8'hFF;
        end else if (i[7:0] == 8'hFF) begin
            // payload never carries 0xFF so the marker stays unique
            v = 8'hFE;
        end else begin
            v = i[7:0];
        end
        return v;
    endfunction

    // build strobe, last flag and byte lanes for the current beat
    always_comb begin
        last = (beat == nbeats - CNT_WIDTH'(1));
        sh   = 4'd8 - {1'b0, rem};
        strb = '1;
        if (last && rem != 3'd0)
            strb = 8'hFF >> sh;
        data = '0;
        idx  = '0;
        for (int b = 0; b < 8; b++) begin
            idx = {beat, 3'(b)};
            if (strb[b])
                data[8*b +: 8] = byte_at(idx);
        end
    end

endmodule

// File: rtl/train_pkt_gen.sv
// Packet-train generator: FSM, counters and config latch.
// Stream outputs decode from registered state, so they hold under stall.
module train_pkt_gen
    import train_pkt_gen_pkg::*;
#(
    parameter int          AXI_DATA_WIDTH = 64,
    parameter logic [15:0] ETHERTYPE      = 16'h88B5,
    parameter int          CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] train_len,
    input  logic [CNT_WIDTH-1:0] pkt_len,
    input  logic [CNT_WIDTH-1:0] ifg_cycles,
    input  logic [47:0]          dst_mac,
    input  logic [47:0]          src_mac,
    train_pkt_gen_if.master      axis,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pkt_sent
);

    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] beat, gap_cnt, tl, pl, ifg;
    logic [CNT_WIDTH-1:0] pl_c, ifg_c, nbeats;
    logic [47:0]          dmac, smac;
    logic                 abort_seen;
    logic                 send, fire;
    logic [DATA_W-1:0]    f_data;
    logic [DATA_W/8-1:0]  f_strb;
    logic                 f_last;

    // clamp the requested length and force a gap of at least one beat
    always_comb begin
        pl_c = pkt_len;
        if (pkt_len < CNT_WIDTH'(PKT_MIN))
            pl_c = CNT_WIDTH'(PKT_MIN);
        else if (pkt_len > CNT_WIDTH'(PKT_MAX))
            pl_c = CNT_WIDTH'(PKT_MAX);
        ifg_c = (ifg_cycles == '0) ? CNT_WIDTH'(1) : ifg_cycles;
    end

    assign nbeats = (pl + CNT_WIDTH'(BYTES - 1)) >> SHIFT;

    train_pkt_gen_word_fmt #(
        .CNT_WIDTH (CNT_WIDTH),
        .ETHERTYPE (ETHERTYPE)
    ) u_fmt (
        .beat      (beat),
        .nbeats    (nbeats),
        .rem       (pl[2:0]),
        .train_len (tl),
        .seq       (pkt_sent),
        .dst_mac   (dmac),
        .src_mac   (smac),
        .data      (f_data),
        .strb      (f_strb),
        .last      (f_last)
    );

    assign send        = (state == ST_SEND);
    assign fire        = send & axis.tready;
    assign axis.tvalid = send;
    assign axis.tdata  = send ? f_data : '0;
    assign axis.tstrb  = send ? f_strb : '0;
    assign axis.tlast  = send & f_last;
    assign busy        = send | (state == ST_GAP);
    assign done        = (state == ST_FIN);

    // train sequencing: latch on start, step beats, time gaps
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            beat       <= '0;
            gap_cnt    <= '0;
            tl         <= '0;
            pl         <= '0;
            ifg        <= '0;
            dmac       <= '0;
            smac       <= '0;
            abort_seen <= 1'b0;
            pkt_sent   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tl         <= train_len;
                        pl         <= pl_c;
                        ifg        <= ifg_c;
                        dmac       <= dst_mac;
                        smac       <= src_mac;
                        pkt_sent   <= '0;
                        abort_seen <= 1'b0;
                        beat       <= '0;
                        state      <= (train_len == '0) ? ST_FIN
                                                        : ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort)
                        abort_seen <= 1'b1;
                    if (fire) begin
                        if (f_last) begin
                            pkt_sent <= pkt_sent + CNT_WIDTH'(1);
                            gap_cnt  <= CNT_WIDTH'(1);
                            state    <= ST_GAP;
                        end else begin
                            beat <= beat + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (abort)
                        abort_seen <= 1'b1;
                    if (gap_cnt >= ifg) begin
                        beat  <= '0;
                        state <= (pkt_sent == tl || abort_seen || abort)
                                 ? ST_FIN : ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_train_pkt_gen.sv
// Directed bench for the packet-train generator.
// A negedge monitor logs accepted beats; tasks check them.
module tb_train_pkt_gen;

    logic        clk = 1'b0;
    logic        resetn, start, abort;
    logic [15:0] train_len, pkt_len, ifg_cycles;
    logic [47:0] dst_mac, src_mac;
    logic        busy, done;
    logic [15:0] pkt_sent;

    train_pkt_gen_if axis();

    train_pkt_gen #(
        .AXI_DATA_WIDTH (64),
        .ETHERTYPE      (16'h88B5),
        .CNT_WIDTH      (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .train_len  (train_len),
        .pkt_len    (pkt_len),
        .ifg_cycles (ifg_cycles),
        .dst_mac    (dst_mac),
        .src_mac    (src_mac),
        .axis       (axis),
        .busy       (busy),
        .done       (done),
        .pkt_sent   (pkt_sent)
    );

    initial forever #5 clk = ~clk;

    localparam logic [47:0] DM = 48'h02_11_22_33_44_55;
    localparam logic [47:0] SM = 48'h02_AA_BB_CC_DD_EE;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int stall_viol = 0;
    int idle_viol = 0;
    logic        stall_pend = 1'b0;
    logic [73:0] prev_beat = '0;

    logic [63:0] q_data[$];
    logic [7:0]  q_strb[$];
    logic        q_last[$];
    int          q_cyc[$];
    int          d_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // log accepted beats, done pulses and stall/idle violations
    always @(negedge clk) begin
        if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
            q_data.push_back(axis.tdata);
            q_strb.push_back(axis.tstrb);
            q_last.push_back(axis.tlast);
            q_cyc.push_back(cyc);
        end
        if (done === 1'b1) d_cyc.push_back(cyc);
        if (stall_pend && resetn === 1'b1 &&
            {axis.tvalid, axis.tlast, axis.tstrb, axis.tdata} !== prev_beat)
            stall_viol <= stall_viol + 1;
        stall_pend <= (axis.tvalid === 1'b1) && (axis.tready !== 1'b1);
        prev_beat  <= {axis.tvalid, axis.tlast, axis.tstrb, axis.tdata};
        if (axis.tvalid !== 1'b1 && axis.tstrb !== 8'h00)
            idle_viol <= idle_viol + 1;
    end

    function automatic logic [7:0] exp_byte(int i, int seq, int tl,
                                            logic [47:0] dm,
                                            logic [47:0] sm);
        logic [15:0] s16, t16;
        s16 = 16'(seq);
        t16 = 16'(tl);
        if (i < 6)   return dm[8*(5-i) +: 8];
        if (i < 12)  return sm[8*(11-i) +: 8];
        if (i == 12) return 8'h88;
        if (i == 13) return 8'hB5;
        if (i == 14) return s16[15:8];
        if (i == 15) return s16[7:0];
        if (i == 16) return t16[15:8];
        if (i == 17) return t16[7:0];
        if (i < 42)  return 8'h00;
        if (i < 50)  return 8'hFF;
        if (i % 256 == 255) return 8'hFE;
        return 8'(i % 256);
    endfunction

    function automatic int frame_errs(int base, int pl, int seq, int tl,
                                      logic [47:0] dm, logic [47:0] sm);
        int nb, rem, e;
        logic [7:0]  es;
        logic [63:0] w;
        nb  = (pl + 7) / 8;
        rem = pl % 8;
        e   = 0;
        if (base + nb > q_data.size()) return 1000;
        for (int k = 0; k < nb; k++) begin
            es = (k == nb - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
            if (q_strb[base+k] !== es) e++;
            if (q_last[base+k] !== (k == nb - 1)) e++;
            w = q_data[base+k];
            for (int b = 0; b < 8; b++)
                if (es[b] && w[8*b +: 8] !== exp_byte(8*k + b, seq, tl, dm, sm))
                    e++;
        end
        return e;
    endfunction

    task automatic clear_logs();
        q_data.delete();
        q_strb.delete();
        q_last.delete();
        q_cyc.delete();
        d_cyc.delete();
    endtask

    task automatic launch(input int tl, input int pl, input int ifg,
                          input logic [47:0] dm, input logic [47:0] sm,
                          output int s);
        @(posedge clk); #1;
        train_len  = 16'(tl);
        pkt_len    = 16'(pl);
        ifg_cycles = 16'(ifg);
        dst_mac    = dm;
        src_mac    = sm;
        start      = 1'b1;
        s          = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (d_cyc.size() != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q_data.size() >= n) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        train_len = '0;
        pkt_len = '0;
        ifg_cycles = '0;
        dst_mac = '0;
        src_mac = '0;
        axis.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({axis.tvalid, axis.tlast, busy, done} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got=%b want=0000",
                     {axis.tvalid, axis.tlast, busy, done});
        end
        n_cmp++;
        if (axis.tstrb !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_tstrb got=%h want=00", axis.tstrb);
        end
        n_cmp++;
        if (axis.tdata !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_tdata got=%h want=0", axis.tdata);
        end
        n_cmp++;
        if (pkt_sent !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_pkt_sent got=%0d want=0", pkt_sent);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_basic_train();
        int s, e;
        bit ok;
        clear_logs();
        launch(3, 64, 4, DM, SM, s);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy got=%b want=1", busy);
        end
        wait_done(200, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL basic_timeout got=no_done want=done");
        end
        n_cmp++;
        if (q_data.size() !== 24) begin
            n_bad++;
            $display("FAIL basic_beats got=%0d want=24", q_data.size());
        end
        if (q_data.size() >= 24 && d_cyc.size() > 0) begin
            for (int f = 0; f < 3; f++) begin
                e = frame_errs(8*f, 64, f, 3, DM, SM);
                n_cmp++;
                if (e !== 0) begin
                    n_bad++;
                    $display("FAIL basic_frame%0d got=%0d_errs want=0", f, e);
                end
            end
            n_cmp++;
            if (q_data[5][63:16] !== 48'hFFFF_FFFF_FFFF ||
                q_data[6][15:0] !== 16'hFFFF) begin
                n_bad++;
                $display("FAIL basic_marker got=%h_%h want=ffffffffffff_ffff",
                         q_data[5][63:16], q_data[6][15:0]);
            end
            n_cmp++;
            if (q_cyc[0] - s !== 1) begin
                n_bad++;
                $display("FAIL basic_latency got=%0d want=1", q_cyc[0] - s);
            end
            n_cmp++;
            if (q_cyc[8] - q_cyc[7] !== 5) begin
                n_bad++;
                $display("FAIL basic_gap got=%0d want=5", q_cyc[8] - q_cyc[7]);
            end
            n_cmp++;
            if (d_cyc[0] - q_cyc[23] !== 5) begin
                n_bad++;
                $display("FAIL basic_done_time got=%0d want=5",
                         d_cyc[0] - q_cyc[23]);
            end
        end
        n_cmp++;
        if (pkt_sent !== 16'd3) begin
            n_bad++;
            $display("FAIL basic_pkt_sent got=%0d want=3", pkt_sent);
        end
        n_cmp++;
        if (idle_viol !== 0) begin
            n_bad++;
            $display("FAIL basic_idle_tstrb got=%0d want=0", idle_viol);
        end
    endtask

    task automatic test_len_clamp();
        int s, e, nb, pl_eff;
        bit ok;
        int req[3]  = '{61, 20, 2000};
        int effv[3] = '{61, 60, 1514};
        logic [7:0] ls[3] = '{8'h1F, 8'h0F, 8'h03};
        for (int t = 0; t < 3; t++) begin
            clear_logs();
            pl_eff = effv[t];
            nb = (pl_eff + 7) / 8;
            launch(1, req[t], 1, DM, SM, s);
            wait_done(400, ok);
            n_cmp++;
            if (!ok || q_data.size() !== nb) begin
                n_bad++;
                $display("FAIL clamp%0d_beats got=%0d want=%0d",
                         req[t], q_data.size(), nb);
            end
            if (q_data.size() == nb) begin
                n_cmp++;
                if (q_strb[nb-1] !== ls[t]) begin
                    n_bad++;
                    $display("FAIL clamp%0d_tstrb got=%h want=%h",
                             req[t], q_strb[nb-1], ls[t]);
                end
                e = frame_errs(0, pl_eff, 0, 1, DM, SM);
                n_cmp++;
                if (e !== 0) begin
                    n_bad++;
                    $display("FAIL clamp%0d_bytes got=%0d_errs want=0",
                             req[t], e);
                end
            end
        end
        if (q_data.size() == 190) begin
            n_cmp++;
            if (q_data[31][63:56] !== 8'hFE) begin
                n_bad++;
                $display("FAIL byte255 got=%h want=fe", q_data[31][63:56]);
            end
        end
    endtask

    task automatic test_stall();
        int s, e;
        bit ok;
        clear_logs();
        launch(5, 100, 2, DM, SM, s);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            axis.tready = 1'($urandom_range(0, 1));
            if (d_cyc.size() != 0) begin
                ok = 1'b1;
                break;
            end
        end
        axis.tready = 1'b1;
        n_cmp++;
        if (!ok || q_data.size() !== 65) begin
            n_bad++;
            $display("FAIL stall_beats got=%0d want=65", q_data.size());
        end
        e = 0;
        for (int f = 0; f < 5; f++)
            e += frame_errs(13*f, 100, f, 5, DM, SM);
        n_cmp++;
        if (e !== 0) begin
            n_bad++;
            $display("FAIL stall_bytes got=%0d_errs want=0", e);
        end
        n_cmp++;
        if (stall_viol !== 0) begin
            n_bad++;
            $display("FAIL stall_stable got=%0d_changes want=0", stall_viol);
        end
        n_cmp++;
        if (pkt_sent !== 16'd5) begin
            n_bad++;
            $display("FAIL stall_pkt_sent got=%0d want=5", pkt_sent);
        end
    endtask

    task automatic test_abort();
        int s, e;
        bit ok;
        clear_logs();
        launch(10, 64, 3, DM, SM, s);
        wait_beats(11, 100);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done(200, ok);
        n_cmp++;
        if (!ok || q_data.size() !== 16) begin
            n_bad++;
            $display("FAIL abort_beats got=%0d want=16", q_data.size());
        end
        if (q_data.size() == 16 && d_cyc.size() > 0) begin
            e = frame_errs(8, 64, 1, 10, DM, SM);
            n_cmp++;
            if (e !== 0 || q_last[15] !== 1'b1) begin
                n_bad++;
                $display("FAIL abort_frame got=%0d_errs want=0", e);
            end
            n_cmp++;
            if (d_cyc[0] - q_cyc[15] !== 4) begin
                n_bad++;
                $display("FAIL abort_done_time got=%0d want=4",
                         d_cyc[0] - q_cyc[15]);
            end
        end
        n_cmp++;
        if (pkt_sent !== 16'd2) begin
            n_bad++;
            $display("FAIL abort_pkt_sent got=%0d want=2", pkt_sent);
        end
    endtask

    task automatic test_zero_and_busy();
        int s, e;
        bit ok;
        clear_logs();
        launch(0, 64, 4, DM, SM, s);
        wait_done(5, ok);
        n_cmp++;
        if (!ok || d_cyc.size() == 0 ||
            d_cyc[0] - s < 1 || d_cyc[0] - s > 2) begin
            n_bad++;
            $display("FAIL zero_done got=%0d want=1..2",
                     (d_cyc.size() != 0) ? d_cyc[0] - s : -1);
        end
        n_cmp++;
        if (q_data.size() !== 0 || pkt_sent !== 16'd0) begin
            n_bad++;
            $display("FAIL zero_no_frames got=%0d/%0d want=0/0",
                     q_data.size(), pkt_sent);
        end
        clear_logs();
        launch(2, 64, 0, DM, SM, s);
        wait_beats(3, 50);
        train_len  = 16'd7;
        pkt_len    = 16'd200;
        ifg_cycles = 16'd9;
        dst_mac    = 48'hFFFF_FFFF_FFFF;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, ok);
        n_cmp++;
        if (!ok || q_data.size() !== 16) begin
            n_bad++;
            $display("FAIL busy_start_beats got=%0d want=16", q_data.size());
        end
        e = frame_errs(0, 64, 0, 2, DM, SM) + frame_errs(8, 64, 1, 2, DM, SM);
        n_cmp++;
        if (e !== 0) begin
            n_bad++;
            $display("FAIL busy_start_cfg got=%0d_errs want=0", e);
        end
        if (q_data.size() == 16) begin
            n_cmp++;
            if (q_cyc[8] - q_cyc[7] !== 2) begin
                n_bad++;
                $display("FAIL ifg0_gap got=%0d want=2", q_cyc[8] - q_cyc[7]);
            end
        end
        n_cmp++;
        if (pkt_sent !== 16'd2) begin
            n_bad++;
            $display("FAIL busy_start_pkt_sent got=%0d want=2", pkt_sent);
        end
    endtask

    task automatic test_reset_mid_frame();
        int s, e;
        bit ok;
        clear_logs();
        launch(3, 64, 4, DM, SM, s);
        wait_beats(3, 50);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({axis.tvalid, axis.tlast, axis.tstrb, busy} !== 11'b0 ||
            axis.tdata !== 64'h0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs got=%b_%h want=0",
                     {axis.tvalid, axis.tlast, axis.tstrb, busy}, axis.tdata);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        clear_logs();
        launch(1, 60, 1, DM, SM, s);
        wait_done(50, ok);
        e = frame_errs(0, 60, 0, 1, DM, SM);
        n_cmp++;
        if (!ok || q_data.size() !== 8 || e !== 0) begin
            n_bad++;
            $display("FAIL rst_mid_restart got=%0d_beats_%0d_errs want=8_0",
                     q_data.size(), e);
        end
        n_cmp++;
        if (pkt_sent !== 16'd1) begin
            n_bad++;
            $display("FAIL rst_mid_pkt_sent got=%0d want=1", pkt_sent);
        end
    endtask

    initial begin
        test_reset();
        test_basic_train();
        test_len_clamp();
        test_stall();
        test_abort();
        test_zero_and_busy();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
